// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction
// memory and queues {pc, instruction} pairs for decode behind a small FIFO.
module imem_fetch_ctrl #(
    parameter int          ADDR_W    = 5,
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_dout,
    input  logic              i_redirect_valid,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [31:0]       o_inst_out,
    output logic [31:0]       o_inst_pc,
    output logic              o_fetch_fault,
    output logic [31:0]       o_fault_pc
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [31:0]       PC_LIMIT = 32'(MEM_WORDS * 4);

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_fault;
    logic [31:0]      r_fault_pc;
    logic [31:0]      r_buf_pc   [DEPTH];
    logic [31:0]      r_buf_inst [DEPTH];

    logic w_pop;
    logic w_bad;
    logic w_can_push;
    logic w_fetch;
    logic w_push;

    always_comb begin
        w_pop      = (r_count != '0) & i_inst_ready;
        w_bad      = (r_pc[1:0] != 2'b00) | (r_pc >= PC_LIMIT);
        w_can_push = (r_count < DEPTH_C) | w_pop;
        w_fetch    = ~i_redirect_valid & ~r_fault & ~w_bad & w_can_push;
        w_push     = w_fetch & ~i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0;
        end else if (i_redirect_valid) begin
            // A head popped this cycle is consumed by decode; everything else is dropped.
            r_pc    <= i_redirect_pc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_tail <= r_tail + PTR_W'(1);
                r_pc   <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_fetch, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (~r_fault & w_bad) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_pc;
            end
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_pc[r_tail]   <= r_pc;
            r_buf_inst[r_tail] <= i_imem_dout;
        end
    end

    assign o_imem_addr   = r_pc[ADDR_W+1:2];
    assign o_inst_valid  = (r_count != '0);
    assign o_inst_out    = r_buf_inst[r_head];
    assign o_inst_pc     = r_buf_pc[r_head];
    assign o_fetch_fault = r_fault;
    assign o_fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios followed by random
// ready/redirect/reset traffic, checked against a queue-based reference model.
module tb_imem_fetch_ctrl;

    localparam int          ADDR_W    = 5;
    localparam int          MEM_WORDS = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 2;

    logic              i_clk;
    logic              i_rst;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       i_imem_dout;
    logic              i_redirect_valid;
    logic [31:0]       i_redirect_pc;
    logic              o_inst_valid;
    logic              i_inst_ready;
    logic [31:0]       o_inst_out;
    logic [31:0]       o_inst_pc;
    logic              o_fetch_fault;
    logic [31:0]       o_fault_pc;

    logic [31:0] mem [MEM_WORDS];

    // Reference model state
    logic [31:0] m_pc;
    bit          m_fault;
    logic [31:0] m_fault_pc;
    logic [63:0] exp_q [$];
    bit          started;

    int checks;
    int errors;

    imem_fetch_ctrl #(
        .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .o_imem_addr(o_imem_addr),
        .i_imem_dout(i_imem_dout),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc(i_redirect_pc),
        .o_inst_valid(o_inst_valid),
        .i_inst_ready(i_inst_ready),
        .o_inst_out(o_inst_out),
        .o_inst_pc(o_inst_pc),
        .o_fetch_fault(o_fetch_fault),
        .o_fault_pc(o_fault_pc)
    );

    assign i_imem_dout = mem[o_imem_addr];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch happens when the PC is legal, no fault is pending and the
    // queue (after this cycle's pop, already removed by the monitor) has room.
    task automatic model_edge();
        logic [63:0] ent;
        if (i_rst) begin
            m_pc       = RESET_PC;
            m_fault    = 1'b0;
            m_fault_pc = 32'h0;
            exp_q.delete();
        end else if (i_redirect_valid) begin
            m_pc    = i_redirect_pc;
            m_fault = 1'b0;
            exp_q.delete();
        end else if (!m_fault) begin
            if ((m_pc % 4 != 0) || (m_pc >= MEM_WORDS * 4)) begin
                m_fault    = 1'b1;
                m_fault_pc = m_pc;
            end else if (exp_q.size() < DEPTH) begin
                ent = {m_pc, mem[m_pc / 4]};
                exp_q.push_back(ent);
                m_pc = m_pc + 4;
            end
        end
    endtask

    // Monitor: compare the head whenever the model expects one, pop on handshake.
    always @(negedge i_clk) begin
        logic [63:0] ent;
        if (started) begin
            chk("inst_valid", {31'b0, o_inst_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                ent = exp_q[0];
                chk("inst_pc", o_inst_pc, ent[63:32]);
                chk("inst_out", o_inst_out, ent[31:0]);
                if (i_inst_ready) void'(exp_q.pop_front());
            end
            chk("fetch_fault", {31'b0, o_fetch_fault}, {31'b0, m_fault});
            chk("fault_pc", o_fault_pc, m_fault_pc);
            chk("imem_addr", {27'b0, o_imem_addr}, {27'b0, m_pc[6:2]});
        end
    end

    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        i_rst            = rst;
        i_inst_ready     = rdy;
        i_redirect_valid = rv;
        i_redirect_pc    = rpc;
        @(posedge i_clk);
        model_edge();
        started = 1'b1;
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
            1:       t = 32'd112 + 32'($urandom_range(0, 6)) * 4;
            2:       t = 32'($urandom_range(0, 127)) | 32'd1;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = 32'(k + 100);
        i_rst            = 1'b1;
        i_inst_ready     = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'h0;

        // Reset then free run, then backpressure and release
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        run(2, 1'b1);
        run(5, 1'b0);
        run(6, 1'b1);

        // Redirect with a full FIFO while the head is being accepted
        step(1'b0, 1'b1, 1'b1, 32'd8);
        run(3, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'd40);
        run(4, 1'b1);

        // Run off the end of memory
        step(1'b0, 1'b1, 1'b1, 32'd120);
        run(8, 1'b1);

        // Misaligned redirect, then recovery
        step(1'b0, 1'b1, 1'b1, 32'd6);
        run(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'd16);
        run(4, 1'b1);

        // Reset while full and faulted, with a competing redirect
        step(1'b0, 1'b0, 1'b1, 32'd120);
        run(4, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'd40);
        run(4, 1'b1);

        // Random traffic with random memory contents
        for (int k = 0; k < MEM_WORDS; k++) mem[k] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            logic r, rv;
            r  = ($urandom_range(0, 199) == 0);
            rv = ($urandom_range(0, 19) == 0);
            step(r, ($urandom_range(0, 9) < 7), rv, rand_target());
        end
        run(4, 1'b1);

        @(negedge i_clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer that drives the combinational instruction memory.
- Owns the program counter and issues word addresses to the memory.
- Captures each returned instruction, with its PC, into a small FIFO and presents it to decode over a valid/ready handshake.
- Handles redirects (branch/jump) by flushing, and stops fetching on misaligned or out-of-range PCs.

Parameters:
- ADDR_W, 5, instruction memory word-address width.
- MEM_WORDS, 32, number of implemented words; byte PCs at or above MEM_WORDS*4 are out of range.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- DEPTH, 2, FIFO entries (power of two, 2 or greater).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  word address to instruction memory, equal to pc[ADDR_W+1:2]
- imem_dout  in  32  instruction returned combinationally for imem_addr in the same cycle
- redirect_valid  in  1  load new PC and flush FIFO this cycle
- redirect_pc  in  32  target byte PC
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_out  out  32  head instruction
- inst_pc  out  32  byte PC of head instruction
- fetch_fault  out  1  sticky; fetch halted on bad PC
- fault_pc  out  32  PC that caused the fault

Behaviour:
- **Reset** (rst=1 at edge): pc=RESET_PC, FIFO empty, inst_valid=0, fetch_fault=0, fault_pc=0. rst has priority over every other input.
- **Internal signals**, defined per cycle:
  - pop = inst_valid & inst_ready.
  - bad = (pc[1:0]!=0) | (pc >= MEM_WORDS*4).
  - can_push = (count < DEPTH) | pop.
  - fetch = ~redirect_valid & ~fetch_fault & ~bad & can_push.
- **Fetch** (fetch=1): push {pc, imem_dout} at the tail and set pc <= pc+4.
  - Instruction latency from address to FIFO entry is 1 cycle.
  - Entries reach inst_valid the cycle after capture.
- **Stall**: with the FIFO full and no pop, there is no push and pc holds. imem_addr keeps showing the held PC.
- **Simultaneous pop and push when full**: both occur; count is unchanged; order is preserved.
- **Output**: inst_out and inst_pc come from the FIFO head and are stable while inst_valid=1 and inst_ready=0. When the FIFO is empty, inst_out and inst_pc are don't-care.
- **Redirect** (redirect_valid=1, rst=0):
  - FIFO cleared (count=0, including any entry popped this cycle, which is still counted as consumed by decode).
  - pc <= redirect_pc; fetch_fault <= 0.
  - No push that cycle.
  - First fetch from the new PC happens the next cycle, and its instruction is valid on the cycle after that.
- **Fault** (~redirect_valid & ~fetch_fault & bad):
  - fetch_fault <= 1 and fault_pc <= pc; no push; pc holds.
  - The FIFO continues to drain normally.
  - Only a redirect or reset clears the fault.
  - A redirect to a bad PC faults one cycle later.
- **Wrap**: pc is a 32-bit increment with no wrap inside memory. Reaching MEM_WORDS*4 faults rather than wrapping to 0.
- **imem_addr**: always pc[ADDR_W+1:2], including during fault and stall.
- **Counters**: count is width $clog2(DEPTH)+1; head and tail pointers wrap modulo DEPTH.

Test Plan:
1. **Reset then free run**
   - Stimulus: rst for 2 cycles, then inst_ready=1, memory word k = k+100.
   - Required: inst_valid first high on the 2nd cycle after rst deasserts. Then one instruction per cycle: inst_pc 0,4,8…, inst_out 100,101,102….
2. **Backpressure**
   - Stimulus: inst_ready=0 for 5 cycles from cycle 3.
   - Required: FIFO fills to 2, pc stops at 12, imem_addr holds 3, and the head stays inst_pc=4.
   - On release: PCs 4,8,12,16 are delivered in order with no duplicates or gaps.
3. **Redirect with full FIFO**
   - Stimulus: FIFO holds PCs 8 and 12, inst_ready=1, redirect_valid=1 with redirect_pc=40.
   - Required: the head in that cycle is accepted. Next cycle inst_valid=0. The cycle after, inst_pc=40 and inst_out=word 10.
4. **Out-of-range**
   - Stimulus: redirect to 120, inst_ready=1.
   - Required: instructions for 120 and 124 are delivered. Then fetch_fault=1 with fault_pc=128, pc holds 128, and inst_valid drops once drained.
5. **Misaligned redirect and recovery**
   - Stimulus: redirect_pc=6.
   - Required: fetch_fault=1 with fault_pc=6 the next cycle and no pushes.
   - Then: redirect_pc=16 clears fetch_fault the same edge, and inst_pc=16 appears 2 cycles later.
6. **Reset mid-stream**
   - Stimulus: rst asserted while FIFO is full and fetch_fault=1.
   - Required: next cycle inst_valid=0, fetch_fault=0, fault_pc=0, pc=RESET_PC, and this dominates a simultaneous redirect_valid.
